// File: rtl/md_ctrl.sv
// Multiply/divide sequencing control: accepts MD-class ops, times the datapath
// latency and strobes HI/LO writes. Optional abort input under macro MD_ABORT_EN.
module md_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  input  logic [2:0] op,
  input  logic       div_zero,
`ifdef MD_ABORT_EN
  input  logic       abort,
`endif
  output logic       md_start,
  output logic       md_sign,
  output logic       md_div,
  output logic       busy,
  output logic       stall,
  output logic       hi_we,
  output logic       lo_we,
  output logic       wsel,
  output logic       rd_hi,
  output logic       rd_lo,
  output logic       div0_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter preload: BUSY covers LAT-1 cycles, DONE is the final one.
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 2);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 2);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_div0;

  logic w_abort;
  logic w_live;
  logic w_idle;
  logic w_issue;
  logic w_accept;
  logic w_move;
  logic w_done;

`ifdef MD_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_live   = ~reset;
  assign w_idle   = (r_state == S_IDLE);
  assign w_issue  = op_valid & w_idle;
  assign w_accept = w_issue & ~op[2];
  assign w_move   = w_issue & op[2] & op[1];
  assign w_done   = (r_state == S_DONE) & ~w_abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_div0  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt   <= op[1] ? DIV_CNT : MUL_CNT;
            r_div0  <= op[1] & div_zero;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_abort) begin
            r_cnt   <= 4'd0;
            r_div0  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_cnt == 4'd0) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          r_cnt   <= 4'd0;
          r_div0  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_cnt   <= 4'd0;
          r_div0  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes are combinational so the pipeline sees them in the issue cycle;
  // every one is forced low while reset is held.
  always_comb begin
    md_start = w_live & w_accept;
    md_sign  = w_live & w_accept & ~op[0];
    md_div   = w_live & w_accept & op[1];
    busy     = w_live & ~w_idle;
    stall    = w_live & op_valid & ~w_idle;
    hi_we    = w_live & ((w_done & ~r_div0) | (w_move & ~op[0]));
    lo_we    = w_live & ((w_done & ~r_div0) | (w_move & op[0]));
    wsel     = w_live & w_move;
    rd_hi    = w_live & w_issue & (op == 3'd4);
    rd_lo    = w_live & w_issue & (op == 3'd5);
    div0_err = w_live & w_done & r_div0;
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Scoreboard bench for md_ctrl: a timestamp-based reference model predicts the
// strobes each cycle; a monitor compares them on the falling edge.
module tb_md_ctrl;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       op_valid = 1'b0;
  logic [2:0] op = 3'd0;
  logic       div_zero = 1'b0;
  logic       abort = 1'b0;
  logic md_start, md_sign, md_div, busy, stall, hi_we, lo_we, wsel, rd_hi, rd_lo, div0_err;

  md_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .div_zero(div_zero),
`ifdef MD_ABORT_EN
    .abort(abort),
`endif
    .md_start(md_start), .md_sign(md_sign), .md_div(md_div), .busy(busy),
    .stall(stall), .hi_we(hi_we), .lo_we(lo_we), .wsel(wsel),
    .rd_hi(rd_hi), .rd_lo(rd_lo), .div0_err(div0_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] v;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model: an op in flight is described by its accept cycle and latency.
  int t = 0;
  bit inflight = 0;
  int acc_t = 0;
  int lat = 0;
  bit dz_l = 0;

  task automatic drive(input bit v, input logic [2:0] o, input bit dz, input bit ab, input bit rs);
    bit m_busy, m_idle, m_done, st, sg, dv, hw, lw, ws, rh, rl, de, stl;
    exp_t e;
    @(posedge clk);
    #1;
    reset = rs; op_valid = v; op = o; div_zero = dz; abort = ab;
`ifndef MD_ABORT_EN
    ab = 1'b0;
`endif
    if (rs) begin
      inflight = 0;
      e.v = '0;
    end else begin
      m_busy = inflight && (t > acc_t) && (t <= acc_t + lat);
      m_idle = !m_busy;
      m_done = m_busy && (t == acc_t + lat) && !ab;
      st  = v && m_idle && (o <= 3'd3);
      sg  = st && (o == 3'd0 || o == 3'd2);
      dv  = st && (o == 3'd2 || o == 3'd3);
      stl = v && m_busy;
      hw  = (m_done && !dz_l) || (v && m_idle && o == 3'd6);
      lw  = (m_done && !dz_l) || (v && m_idle && o == 3'd7);
      ws  = v && m_idle && (o == 3'd6 || o == 3'd7);
      rh  = v && m_idle && o == 3'd4;
      rl  = v && m_idle && o == 3'd5;
      de  = m_done && dz_l;
      e.v = {st, sg, dv, m_busy, stl, hw, lw, ws, rh, rl, de};
      if (m_busy && (t == acc_t + lat || ab)) inflight = 0;
      if (st) begin
        inflight = 1;
        acc_t = t;
        lat = dv ? DIV_LAT : MUL_LAT;
        dz_l = dv && dz;
      end
    end
    e.cyc = t;
    sb.push_back(e);
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 3'($urandom_range(0, 7)), 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [10:0] got;
      e = sb.pop_front();
      got = {md_start, md_sign, md_div, busy, stall, hi_we, lo_we, wsel, rd_hi, rd_lo, div0_err};
      vectors++;
      if (got !== e.v) begin
        miscompares++;
        $display("FAIL outs cyc %0d: got %b want %b (start sign div busy stall hi lo wsel rdhi rdlo d0)",
                 e.cyc, got, e.v);
      end
    end
  end

  initial begin
    drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    idle(2);
    // MULT then MFLO held across the operation
    drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
    idle(2);
    // DIVU with zero divisor
    drive(1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
    idle(11);
    // moves and reads in IDLE
    drive(1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
    idle(1);
    // DIV interrupted by reset, then a clean DIV
    drive(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    idle(3);
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    idle(8);
    drive(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    idle(11);
    // op presented during DONE is held, then accepted
    drive(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    idle(4);
    drive(1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    idle(1);
`ifdef MD_ABORT_EN
    drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    idle(2);
    drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    idle(6);
`endif
    for (int i = 0; i < 3000; i++) begin
      bit v, dz, ab, rs;
      v  = ($urandom_range(0, 99) < 60);
      dz = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 29) == 0);
      rs = ($urandom_range(0, 249) == 0);
      drive(v, 3'($urandom_range(0, 7)), dz, ab, rs);
    end
    idle(2);
    @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
